// File: rtl/rgb_to_yuv_conversion.sv
// Reads packed RGB pixel pairs from SRAM and writes BT.601 Y and interleaved UV (4:2:2) planes back.
// Each pixel pair takes six cycles: three reads, one capture, one Y write and one UV write.
module rgb_to_yuv_conversion #(
    parameter int ADDR_RGB = 0,
    parameter int ADDR_Y   = 115200,
    parameter int ADDR_UV  = 153600,
    parameter int W        = 320,
    parameter int H        = 240,
    parameter int DW       = 16,
    parameter int AW       = 18
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    output logic          done,
    output logic [AW-1:0] raddr,
    input  logic [DW-1:0] rdata,
    output logic [AW-1:0] waddr,
    output logic [DW-1:0] wdata,
    output logic          wr_enable
);

    localparam int NPAIR = W * H / 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD0   = 3'd1,
        S_RD1   = 3'd2,
        S_RD2   = 3'd3,
        S_CAP   = 3'd4,
        S_WR_Y  = 3'd5,
        S_WR_UV = 3'd6,
        S_DONE  = 3'd7
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] p_q, p_d;
    logic [DW-1:0] w0_q, w0_d;
    logic [DW-1:0] w1_q, w1_d;
    logic [DW-1:0] w2_q, w2_d;

    function automatic logic signed [17:0] ext8(input logic [7:0] x);
        return $signed({10'd0, x});
    endfunction

    function automatic logic [7:0] sat8(input logic signed [17:0] v);
        if (v < 18'sd0)
            return 8'd0;
        else if (v > 18'sd255)
            return 8'd255;
        else
            return v[7:0];
    endfunction

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
    endfunction

    function automatic logic [7:0] luma(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic signed [17:0] acc;
        acc = 18'sd66 * ext8(r) + 18'sd129 * ext8(g) + 18'sd25 * ext8(b) + 18'sd128;
        return sat8((acc >>> 8) + 18'sd16);
    endfunction

    function automatic logic [7:0] chroma_u(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic signed [17:0] acc;
        acc = 18'sd112 * ext8(b) - 18'sd38 * ext8(r) - 18'sd74 * ext8(g) + 18'sd128;
        return sat8((acc >>> 8) + 18'sd128);
    endfunction

    function automatic logic [7:0] chroma_v(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        logic signed [17:0] acc;
        acc = 18'sd112 * ext8(r) - 18'sd94 * ext8(g) - 18'sd18 * ext8(b) + 18'sd128;
        return sat8((acc >>> 8) + 18'sd128);
    endfunction

    // Word layout of a pair: {R0,G0}, {B0,R1}, {G1,B1}, high byte first.
    logic [7:0] r0, g0, b0, r1, g1, b1;
    assign r0 = w0_q[15:8];
    assign g0 = w0_q[7:0];
    assign b0 = w1_q[15:8];
    assign r1 = w1_q[7:0];
    assign g1 = w2_q[15:8];
    assign b1 = w2_q[7:0];

    logic [7:0] y0, y1, u_val, v_val;
    logic [7:0] ra, ga, ba;
    assign y0    = luma(r0, g0, b0);
    assign y1    = luma(r1, g1, b1);
    assign ra    = avg8(r0, r1);
    assign ga    = avg8(g0, g1);
    assign ba    = avg8(b0, b1);
    assign u_val = chroma_u(ra, ga, ba);
    assign v_val = chroma_v(ra, ga, ba);

    logic [DW-1:0] y_word, uv_word;
    logic [AW-1:0] rgb_base;
    assign y_word   = DW'({y0, y1});
    assign uv_word  = DW'({u_val, v_val});
    assign rgb_base = AW'(ADDR_RGB) + (p_q << 1) + p_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            p_q     <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            w2_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            w0_q    <= w0_d;
            w1_q    <= w1_d;
            w2_q    <= w2_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        w0_d    = w0_q;
        w1_d    = w1_q;
        w2_d    = w2_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RD0;
                    p_d     = '0;
                end
            end
            S_RD0:  state_d = S_RD1;
            S_RD1: begin
                w0_d    = rdata;
                state_d = S_RD2;
            end
            S_RD2: begin
                w1_d    = rdata;
                state_d = S_CAP;
            end
            S_CAP: begin
                w2_d    = rdata;
                state_d = S_WR_Y;
            end
            S_WR_Y: state_d = S_WR_UV;
            S_WR_UV: begin
                if (p_q == AW'(NPAIR - 1)) begin
                    state_d = S_DONE;
                end else begin
                    p_d     = p_q + AW'(1);
                    state_d = S_RD0;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decode straight from state so an asynchronous reset drops the write strobe at once.
    always_comb begin
        raddr     = '0;
        waddr     = '0;
        wdata     = '0;
        wr_enable = 1'b0;
        done      = 1'b0;
        case (state_q)
            S_RD0: raddr = rgb_base;
            S_RD1: raddr = rgb_base + AW'(1);
            S_RD2: raddr = rgb_base + AW'(2);
            S_WR_Y: begin
                wr_enable = 1'b1;
                waddr     = AW'(ADDR_Y) + p_q;
                wdata     = y_word;
            end
            S_WR_UV: begin
                wr_enable = 1'b1;
                waddr     = AW'(ADDR_UV) + p_q;
                wdata     = uv_word;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_rgb_to_yuv_conversion.sv
// Bench for rgb_to_yuv_conversion: small 4x2 frame, SRAM model, integer reference model of the colour maths.
module tb_rgb_to_yuv_conversion;

    localparam int W     = 4;
    localparam int H     = 2;
    localparam int N     = W * H / 2;
    localparam int AW    = 8;
    localparam int DW    = 16;
    localparam int A_RGB = 2;
    localparam int A_Y   = 20;
    localparam int A_UV  = 30;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          done;
    logic [AW-1:0] raddr;
    logic [DW-1:0] rdata;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic          wr_enable;

    rgb_to_yuv_conversion #(
        .ADDR_RGB(A_RGB), .ADDR_Y(A_Y), .ADDR_UV(A_UV),
        .W(W), .H(H), .DW(DW), .AW(AW)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .done(done),
        .raddr(raddr), .rdata(rdata), .waddr(waddr), .wdata(wdata),
        .wr_enable(wr_enable)
    );

    always #5 clk = ~clk;

    // SRAM: RGB source read with one cycle latency, output planes written on the edge.
    logic [15:0] rgb_mem [256];
    logic [15:0] out_mem [256];
    logic        clr_tog = 1'b0;
    logic        clr_seen = 1'b0;

    always @(posedge clk) begin
        rdata <= rgb_mem[raddr];
        if (clr_tog != clr_seen) begin
            for (int i = 0; i < 256; i++) out_mem[i] <= 16'hDEAD;
            clr_seen <= clr_tog;
        end
        if (wr_enable) out_mem[waddr] <= wdata;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    int pr[2*N], pg[2*N], pb[2*N];

    function automatic int clamp(input int v);
        return (v < 0) ? 0 : ((v > 255) ? 255 : v);
    endfunction
    function automatic int ref_y(input int r, input int g, input int b);
        return clamp(((66*r + 129*g + 25*b + 128) >>> 8) + 16);
    endfunction
    function automatic int ref_u(input int r, input int g, input int b);
        return clamp(((-38*r - 74*g + 112*b + 128) >>> 8) + 128);
    endfunction
    function automatic int ref_v(input int r, input int g, input int b);
        return clamp(((112*r - 94*g - 18*b + 128) >>> 8) + 128);
    endfunction
    function automatic int exp_y_word(input int p);
        return ref_y(pr[2*p], pg[2*p], pb[2*p]) * 256 + ref_y(pr[2*p+1], pg[2*p+1], pb[2*p+1]);
    endfunction
    function automatic int exp_uv_word(input int p);
        int ra, ga, ba;
        ra = (pr[2*p] + pr[2*p+1] + 1) / 2;
        ga = (pg[2*p] + pg[2*p+1] + 1) / 2;
        ba = (pb[2*p] + pb[2*p+1] + 1) / 2;
        return ref_u(ra, ga, ba) * 256 + ref_v(ra, ga, ba);
    endfunction

    function automatic int rnd_byte();
        int k;
        k = int'($urandom_range(0, 7));
        if (k == 0) return 0;
        if (k == 1) return 255;
        return int'($urandom_range(0, 255));
    endfunction

    // kind 0: all white, 1: directed red/blue/white+black/black pairs, else random
    task automatic load_frame(input int kind);
        for (int i = 0; i < 2*N; i++) begin
            if (kind == 0) begin
                pr[i] = 255; pg[i] = 255; pb[i] = 255;
            end else if (kind == 1) begin
                case (i)
                    0, 1: begin pr[i] = 255; pg[i] = 0;   pb[i] = 0;   end
                    2, 3: begin pr[i] = 0;   pg[i] = 0;   pb[i] = 255; end
                    4:    begin pr[i] = 255; pg[i] = 255; pb[i] = 255; end
                    default: begin pr[i] = 0; pg[i] = 0; pb[i] = 0; end
                endcase
            end else begin
                pr[i] = rnd_byte(); pg[i] = rnd_byte(); pb[i] = rnd_byte();
            end
        end
        for (int i = 0; i < 256; i++) rgb_mem[i] = 16'h0000;
        for (int p = 0; p < N; p++) begin
            rgb_mem[A_RGB + 3*p]     = 16'((pr[2*p]   << 8) | pg[2*p]);
            rgb_mem[A_RGB + 3*p + 1] = 16'((pb[2*p]   << 8) | pr[2*p+1]);
            rgb_mem[A_RGB + 3*p + 2] = 16'((pg[2*p+1] << 8) | pb[2*p+1]);
        end
        clr_tog = ~clr_tog;
    endtask

    int lat, first_y, first_uv, first_wa, writes, viol;

    // Caller is just after a falling edge with the DUT idle; returns in the first IDLE cycle after DONE.
    task automatic run(input int pulse_at, input bit start_in_done);
        int n;
        n = 0; lat = -1; first_y = -1; first_uv = -1; first_wa = -1; writes = 0; viol = 0;
        start = 1'b1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
            if (pulse_at > 0 && n == pulse_at) start = 1'b1;
            if (pulse_at > 0 && n == pulse_at + 1) start = 1'b0;
            if (wr_enable) begin
                writes++;
                if (first_wa < 0) first_wa = int'(waddr);
                if (waddr >= AW'(A_Y) && waddr < AW'(A_Y + N)) begin
                    if (first_y < 0) first_y = n;
                end else if (waddr >= AW'(A_UV) && waddr < AW'(A_UV + N)) begin
                    if (first_uv < 0) first_uv = n;
                end else viol++;
            end else if (waddr != '0 || wdata != '0) viol++;
            if (raddr != '0 && (raddr < AW'(A_RGB) || raddr > AW'(A_RGB + 3*N - 1))) viol++;
            if (done) begin
                lat = n;
                break;
            end
        end
        if (start_in_done) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
    endtask

    task automatic check_run(input string tag);
        chk({tag, "_latency"}, lat, 6*N + 1);
        chk({tag, "_first_y_cycle"}, first_y, 5);
        chk({tag, "_first_uv_cycle"}, first_uv, 6);
        chk({tag, "_first_waddr"}, first_wa, A_Y);
        chk({tag, "_writes"}, writes, 2*N);
        chk({tag, "_addr_viol"}, viol, 0);
    endtask

    task automatic check_frame(input string tag, input int np);
        for (int p = 0; p < np; p++) begin
            chk($sformatf("%s_y%0d", tag, p), out_mem[A_Y + p], exp_y_word(p));
            chk($sformatf("%s_uv%0d", tag, p), out_mem[A_UV + p], exp_uv_word(p));
        end
    endtask

    logic [15:0] dir_y [4];
    logic [15:0] dir_uv [4];

    initial begin
        int bad, dcnt, wcnt, n;

        dir_y  = '{16'h5252, 16'h2929, 16'hEB10, 16'h1010};
        dir_uv = '{16'h5AF0, 16'hF06E, 16'h8080, 16'h8080};

        repeat (3) @(negedge clk);
        chk("rst_done", done, 0);
        chk("rst_wr_enable", wr_enable, 0);
        chk("rst_raddr", raddr, 0);
        chk("rst_waddr", waddr, 0);
        chk("rst_wdata", wdata, 0);
        reset = 1'b1;
        @(negedge clk);

        load_frame(0);
        run(0, 1'b0);
        $display("txn white: latency=%0d writes=%0d", lat, writes);
        check_run("white");
        for (int p = 0; p < N; p++) begin
            chk($sformatf("white_const_y%0d", p), out_mem[A_Y + p], 16'hEBEB);
            chk($sformatf("white_const_uv%0d", p), out_mem[A_UV + p], 16'h8080);
        end

        load_frame(1);
        run(0, 1'b0);
        $display("txn directed: latency=%0d writes=%0d", lat, writes);
        check_run("dir");
        for (int p = 0; p < N; p++) begin
            chk($sformatf("dir_const_y%0d", p), out_mem[A_Y + p], dir_y[p]);
            chk($sformatf("dir_const_uv%0d", p), out_mem[A_UV + p], dir_uv[p]);
        end
        check_frame("dir", N);

        // start pulsed mid-run and again during DONE: both must be ignored
        load_frame(2);
        run(10, 1'b1);
        $display("txn random+start_pulses: latency=%0d writes=%0d", lat, writes);
        check_run("midstart");
        check_frame("midstart", N);
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (wr_enable || raddr != '0 || done) bad++;
        end
        chk("start_in_done_ignored", bad, 0);

        // two back-to-back runs
        for (int r = 0; r < 2; r++) begin
            load_frame(2);
            run(0, 1'b0);
            $display("txn back_to_back %0d: latency=%0d writes=%0d", r, lat, writes);
            check_run($sformatf("b2b%0d", r));
            check_frame($sformatf("b2b%0d", r), N);
        end

        // asynchronous reset during the third pair's Y write
        load_frame(2);
        start = 1'b1;
        n = 0;
        while (n < 17) begin
            @(negedge clk);
            n++;
            if (n == 1) start = 1'b0;
        end
        chk("pre_rst_wr_enable", wr_enable, 1);
        chk("pre_rst_waddr", waddr, A_Y + 2);
        reset = 1'b0;
        #1;
        chk("async_rst_wr_enable", wr_enable, 0);
        chk("async_rst_waddr", waddr, 0);
        chk("async_rst_raddr", raddr, 0);
        dcnt = 0; wcnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done) dcnt++;
            if (wr_enable) wcnt++;
        end
        reset = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (done) dcnt++;
            if (wr_enable) wcnt++;
        end
        $display("txn reset_abort: done_pulses=%0d writes_after=%0d", dcnt, wcnt);
        chk("abort_no_done", dcnt, 0);
        chk("abort_no_writes", wcnt, 0);
        check_frame("abort_kept", 2);
        chk("abort_y2_unwritten", out_mem[A_Y + 2], 16'hDEAD);

        load_frame(2);
        run(0, 1'b0);
        $display("txn after_reset: latency=%0d writes=%0d", lat, writes);
        check_run("rerun");
        check_frame("rerun", N);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rgb_to_yuv_conversion.md
# rgb_to_yuv_conversion

- Converts a W×H frame of packed 8-bit RGB pixels in SRAM into BT.601 YUV 4:2:2.
- Writes a Y plane and an interleaved UV plane back to the same SRAM, through one read-only port and one write-only port.
- Sits upstream of the colour-conversion datapath as its inverse: it produces the YUV data that stage consumes.
- One conversion runs per `start` and ends with a one-cycle `done` pulse.

## Interface
Parameters:
- ADDR_RGB, 0: base word address of the RGB input (3·W·H/2 words)
- ADDR_Y, 115200: base of the Y output (W·H/2 words)
- ADDR_UV, 153600: base of the UV output (W·H/2 words)
- W, 320: frame width in pixels (even)
- H, 240: frame height
- DW, 16: SRAM data width
- AW, 18: SRAM address width

Ports:
- clk  in  1  single clock; all state on its rising edge
- reset  in  1  asynchronous, active-low; low forces the reset state immediately
- start  in  1  one-cycle request; sampled only in IDLE
- done  out  1  one-cycle pulse when the last UV word has been written
- raddr  out  AW  SRAM read address
- rdata  in  DW  SRAM read data, valid the cycle after raddr is presented
- waddr  out  AW  SRAM write address
- wdata  out  DW  SRAM write data
- wr_enable  out  1  write strobe; SRAM writes wdata at waddr on the clock edge ending the cycle

## Operation
- Work unit is a horizontal pixel pair p = 0 … W·H/2−1, raster order.
- RGB input, words at ADDR_RGB+3p … +3p+2:
  - {R0,G0}
  - {B0,R1}
  - {G1,B1}
  - High byte first in each word.
- Per pixel:
  - Y = ((66R + 129G + 25B + 128) >>> 8) + 16
- Per pair, with averaged colour Ra=(R0+R1+1)>>1, Ga=(G0+G1+1)>>1, Ba=(B0+B1+1)>>1:
  - U = ((−38Ra − 74Ga + 112Ba + 128) >>> 8) + 128
  - V = ((112Ra − 94Ga − 18Ba + 128) >>> 8) + 128
- Arithmetic:
  - Signed 18-bit intermediates.
  - >>> is arithmetic shift, i.e. floor.
  - Each result saturates to 0…255 before packing.
- Outputs:
  - Y word {Y0,Y1} to ADDR_Y+p.
  - UV word {U,V} to ADDR_UV+p.
- FSM states: IDLE, RD0, RD1, RD2, CAP, WR_Y, WR_UV, DONE.
  - IDLE: raddr=0, wr_enable=0. On start go to RD0 with p=0.
  - RD0: raddr=ADDR_RGB+3p.
  - RD1: raddr=+1; capture rdata into word0.
  - RD2: raddr=+2; capture word1.
  - CAP: capture word2.
  - WR_Y: wr_enable=1, waddr=ADDR_Y+p, wdata={Y0,Y1} computed from captured words.
  - WR_UV: wr_enable=1, waddr=ADDR_UV+p, wdata={U,V}.
    - If p = W·H/2−1, go to DONE.
    - Otherwise increment p and go to RD0.
  - DONE: done=1 for one cycle, then IDLE.
- start during any non-IDLE state is ignored and not queued.
- start asserted in the DONE cycle is also ignored.
- Reset mid-operation:
  - Aborts immediately and returns to IDLE, p=0.
  - SRAM words already written stay written.
  - No done pulse is produced.
- Reset values: done=0, wr_enable=0, raddr=0, waddr=0, wdata=0, p=0, capture registers 0.
- When wr_enable=0, waddr and wdata are held at 0.

## Timing
- Exactly 6 cycles per pair (RD0…WR_UV).
- start seen in IDLE at edge t → RD0 during cycle t+1.
- First Y write during cycle t+5; first UV write during cycle t+6.
- done high 6·(W·H/2)+1 cycles after the start edge: 230401 for 320×240.
- Exactly one write per WR_Y and per WR_UV cycle; never two writes in one cycle.
- Reads occur only in RD0–RD2.
- raddr stays within ADDR_RGB … ADDR_RGB+3·W·H/2−1.
- waddr stays within the Y and UV planes.
- Last pair: no read of address ADDR_RGB+3·W·H/2.
- Back-to-back runs: start in the first IDLE cycle after DONE is accepted.

## Test plan
- All-white frame (words 0xFFFF), reduced W=4,H=2 → every Y word 0xEBEB, every UV word 0x8080; done exactly 25 cycles after start.
- Pair of pure red (words 0xFF00, 0x00FF, 0x0000) → Y word 0x5252, UV word 0x5AF0.
- Pair of pure blue (words 0x0000, 0xFF00, 0x00FF) → Y word 0x2929, UV word 0xF06E.
- Pair white+black (words 0xFFFF, 0xFF00, 0x0000) → Y word 0xEB10; averaged (128,128,128) gives UV word 0x8080. All-black pair → 0x1010 and 0x8080.
- start pulsed again mid-run → ignored; total write count stays W·H; single done pulse.
- reset driven low during the third pair's WR_Y → wr_enable drops within the same cycle (asynchronous); no done. New start after reset rewrites from ADDR_Y+0 with correct data.
